program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
Parametrised successor to the fixed-width UART ROM loader. Consumes a framed byte stream from uart_receiver, assembles little-endian words of DATA_W bits, writes them to a program memory at a host-supplied base address, and holds the system in soft reset for the whole load. Differences from the fixed loader:
- configurable word and address width
- write backpressure handshake
- inter-byte timeout
- sticky error reporting
- optional frame checksum

Parameters:
DATA_W, 32, memory word width; multiple of 8, range 8..64
ADDR_W, 11, memory word-address width; range 1..32
SYNC_BYTE, 8'hA5, frame start byte
TIMEOUT_CYCLES, 1000000, maximum idle clocks between bytes inside a frame; 0 disables the timeout

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
rx_data  in  8  byte from uart_receiver
rx_data_ready  in  1  one-cycle strobe; rx_data is valid in that cycle
write_addr  out  ADDR_W  memory word address
write_data  out  DATA_W  memory write data
write_req  out  1  write request; held until accepted
write_ready  in  1  memory accepts the write in any cycle where write_req && write_ready
system_soft_reset  out  1  holds the CPU in reset
busy  out  1  frame in progress
error  out  1  sticky fault flag
load_done  out  1  one-cycle pulse on successful load

Behaviour:
- Reset: one clock, clk; reset is asynchronous and active-low on reset_n. While reset_n=0, every output is 0 and the FSM is in IDLE.
- Frame format, in byte order:
  - SYNC_BYTE
  - COUNT: 4 bytes, little-endian word count; only the low ADDR_W+1 bits are used
  - BASE: 4 bytes, little-endian word address; only the low ADDR_W bits are used
  - COUNT words, each DATA_W/8 bytes, little-endian
  - [CHK], checksum-enabled builds only
- States: IDLE -> LEN -> BASE -> DATA -> (CHK) -> IDLE.
- IDLE:
  - Bytes other than SYNC_BYTE are ignored.
  - On SYNC_BYTE: the next cycle sets system_soft_reset=1 and busy=1, clears error, and enters LEN.
- LEN and BASE: each consumes exactly 4 bytes. After BASE:
  - COUNT=0: go to CHK if the checksum is compiled in, otherwise finish.
  - Otherwise: enter DATA.
- DATA, word assembly:
  - Bytes are shifted into an assembly register.
  - On the last byte of a word, the word moves to the write holding register with write_addr = BASE + index, modulo 2^ADDR_W (wraps).
  - write_req asserts the cycle after the last byte arrives.
  - Assembly of the next word continues while the write is pending.
- Overrun: a word completes while the previous write_req is still pending.
  - error=1, write_req drops, FSM returns to IDLE.
  - system_soft_reset stays 1.
- After the final word is accepted: go to CHK, or finish.
- Finish, in the cycle after the last write is accepted (or after the checksum byte):
  - system_soft_reset=0, busy=0, load_done=1 for exactly one cycle.
- Timeout: a counter is cleared on every rx_data_ready.
  - It counts only in LEN, BASE, DATA and CHK.
  - Reaching TIMEOUT_CYCLES: error=1, return to IDLE, system_soft_reset stays 1.
- Error state:
  - error stays 1 until the next SYNC_BYTE, which starts a fresh frame.
  - The CPU stays in reset until a successful load.
- A SYNC_BYTE value arriving mid-frame is treated as ordinary data.
- rx_data_ready in the same cycle as a write acceptance: both are handled, with no lost byte.

Optional Feature:
Macro PROGRAM_LOADER_CHECKSUM_EN.
- Defined:
  - The frame carries a trailing CHK byte.
  - An 8-bit running sum covers every byte after SYNC_BYTE, including CHK.
  - Sum = 0 mod 256: finish, once all writes are accepted.
  - Sum != 0: error=1, no load_done, system_soft_reset stays 1.
  - Writes are not rolled back.
- Undefined: no CHK byte is expected, and the frame finishes after the last write is accepted.

Test Plan:
1. DATA_W=32, ADDR_W=11, write_ready=1; send A5 02 00 00 00 10 00 00 00 44 33 22 11 DD CC BB AA -> writes (0x010, 0x11223344) then (0x011, 0xAABBCCDD). system_soft_reset is 1 from the cycle after A5 until the cycle after the second acceptance, then 0; one load_done pulse.
2. Same frame with BASE=0x7FF -> writes to 0x7FF, then 0x000.
3. Hold write_ready=0 while the second word fully arrives -> error=1, busy=0, system_soft_reset=1, no second write, no load_done.
4. TIMEOUT_CYCLES=100; stop sending after BASE -> 100 cycles later error=1 and FSM in IDLE. A following A5 clears error, and a complete frame then loads normally.
5. With PROGRAM_LOADER_CHECKSUM_EN, frame 1 plus CHK=0x36 -> load_done pulse. Same frame with CHK=0x37 -> error=1, system_soft_reset stays 1.
6. Pull reset_n low during DATA -> all outputs 0 immediately. After release, stray bytes 0x00 and 0xFF are ignored, and a full frame loads correctly.

Source files
------------

// File: rtl/program_loader.sv
// Framed UART program loader: SYNC, COUNT, BASE, little-endian DATA words -> memory writes.
// Optional trailing checksum byte when PROGRAM_LOADER_CHECKSUM_EN is defined.
module program_loader #(
  parameter int          DATA_W         = 32,
  parameter int          ADDR_W         = 11,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_data_ready,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] write_data,
  output logic              write_req,
  input  logic              write_ready,
  output logic              system_soft_reset,
  output logic              busy,
  output logic              error,
  output logic              load_done
);

  localparam int           NB       = DATA_W / 8;
  localparam logic [2:0]   LAST_B   = 3'(NB - 1);
  localparam logic [31:0]  TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_BASE, S_DATA, S_CHK, S_WAIT} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  state_t            r_state, w_nxt;
  logic [2:0]        r_bcnt;
  logic [23:0]       r_hdr;
  logic [ADDR_W:0]   r_cnt, r_widx;
  logic [ADDR_W-1:0] r_base;
  wr_t               r_wr;
  logic              r_wreq, r_srst, r_busy, r_err, r_done;
  logic [31:0]       r_tmo;

  logic [31:0]       w_hdr_nxt;
  logic [ADDR_W:0]   w_cnt_val;
  logic [DATA_W-1:0] w_asm_nxt;
  logic w_hdr_byte, w_data_byte, w_hdr_last, w_word_done, w_last_word;
  logic w_acc, w_counting, w_tmo_hit;
  logic w_start, w_load, w_finish, w_fail;

  assign w_hdr_nxt   = {rx_data, r_hdr};
  assign w_counting  = (r_state == S_LEN) || (r_state == S_BASE) ||
                       (r_state == S_DATA) || (r_state == S_CHK);
  assign w_hdr_byte  = rx_data_ready && ((r_state == S_LEN) || (r_state == S_BASE));
  assign w_data_byte = rx_data_ready && (r_state == S_DATA);
  assign w_hdr_last  = (r_bcnt == 3'd3);
  assign w_word_done = w_data_byte && (r_bcnt == LAST_B);
  assign w_last_word = ((r_widx + ONE) == r_cnt);
  assign w_acc       = r_wreq && write_ready;
  assign w_tmo_hit   = (TIMEOUT_CYCLES != 0) && w_counting && !rx_data_ready &&
                       (r_tmo == TMO_LAST);

  generate
    if (ADDR_W >= 32) begin : g_cnt
      assign w_cnt_val = (ADDR_W+1)'(w_hdr_nxt);
    end else begin : g_cnt
      assign w_cnt_val = w_hdr_nxt[ADDR_W:0];
    end
    // Bytes shift in from the top so the first byte ends up least significant.
    if (DATA_W == 8) begin : g_asm
      assign w_asm_nxt = rx_data;
    end else begin : g_asm
      logic [DATA_W-9:0] r_asm;
      always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)         r_asm <= '0;
        else if (w_data_byte) r_asm <= w_asm_nxt[DATA_W-1:8];
      assign w_asm_nxt = {rx_data, r_asm};
    end
  endgenerate

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0] r_sum, w_sum_nxt;
  assign w_sum_nxt = r_sum + rx_data;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n)                         r_sum <= '0;
    else if (w_start)                     r_sum <= '0;
    else if (rx_data_ready && w_counting) r_sum <= w_sum_nxt;
`endif

  always_comb begin
    w_nxt    = r_state;
    w_start  = 1'b0;
    w_load   = 1'b0;
    w_finish = 1'b0;
    w_fail   = 1'b0;
    case (r_state)
      S_IDLE: if (rx_data_ready && rx_data == SYNC_BYTE) begin
        w_start = 1'b1;
        w_nxt   = S_LEN;
      end
      S_LEN: if (w_hdr_byte && w_hdr_last) w_nxt = S_BASE;
      S_BASE: if (w_hdr_byte && w_hdr_last) begin
        if (r_cnt != '0) w_nxt = S_DATA;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        else             w_nxt = S_CHK;
`else
        else             w_finish = 1'b1;
`endif
      end
      S_DATA: if (w_word_done) begin
        // A write accepted in this same cycle frees the holding register.
        if (r_wreq && !write_ready) w_fail = 1'b1;
        else begin
          w_load = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          if (w_last_word) w_nxt = S_CHK;
`else
          if (w_last_word) w_nxt = S_WAIT;
`endif
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      S_CHK: if (rx_data_ready) begin
        if (w_sum_nxt != 8'd0)           w_fail   = 1'b1;
        else if (!r_wreq || write_ready) w_finish = 1'b1;
        else                             w_nxt    = S_WAIT;
      end
`endif
      S_WAIT: if (!r_wreq || write_ready) w_finish = 1'b1;
      default: w_nxt = S_IDLE;
    endcase
    if (w_tmo_hit) w_fail = 1'b1;
    if (w_fail || w_finish) w_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_bcnt  <= '0;
      r_hdr   <= '0;
      r_cnt   <= '0;
      r_base  <= '0;
      r_widx  <= '0;
      r_wr    <= '0;
      r_wreq  <= 1'b0;
      r_srst  <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
      r_tmo   <= '0;
    end else begin
      r_state <= w_nxt;
      r_done  <= w_finish;
      if (rx_data_ready || !w_counting) r_tmo <= '0;
      else                              r_tmo <= r_tmo + 32'd1;
      if (w_hdr_byte) begin
        r_hdr  <= w_hdr_nxt[31:8];
        r_bcnt <= w_hdr_last ? 3'd0 : r_bcnt + 3'd1;
        if (w_hdr_last && r_state == S_LEN)  r_cnt  <= w_cnt_val;
        if (w_hdr_last && r_state == S_BASE) r_base <= w_hdr_nxt[ADDR_W-1:0];
      end
      if (w_data_byte) r_bcnt <= (r_bcnt == LAST_B) ? 3'd0 : r_bcnt + 3'd1;
      if (w_acc) r_wreq <= 1'b0;
      if (w_load) begin
        r_wr.addr <= r_base + r_widx[ADDR_W-1:0];
        r_wr.data <= w_asm_nxt;
        r_wreq    <= 1'b1;
        r_widx    <= r_widx + ONE;
      end
      if (w_start) begin
        r_srst <= 1'b1;
        r_busy <= 1'b1;
        r_err  <= 1'b0;
        r_bcnt <= '0;
        r_widx <= '0;
        r_wreq <= 1'b0;
      end
      // CPU stays in reset after a fault; only a good load releases it.
      if (w_fail) begin
        r_err  <= 1'b1;
        r_busy <= 1'b0;
        r_wreq <= 1'b0;
      end
      if (w_finish) begin
        r_srst <= 1'b0;
        r_busy <= 1'b0;
      end
    end
  end

  assign write_addr        = r_wr.addr;
  assign write_data        = r_wr.data;
  assign write_req         = r_wreq;
  assign system_soft_reset = r_srst;
  assign busy              = r_busy;
  assign error             = r_err;
  assign load_done         = r_done;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader (DATA_W=32, ADDR_W=11, TIMEOUT_CYCLES=100).
// Checksum scenario runs only when PROGRAM_LOADER_CHECKSUM_EN is defined.
module tb_program_loader;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 11;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_data_ready = 1'b0;
  logic              write_ready = 1'b1;
  logic [ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0] write_data;
  logic              write_req, system_soft_reset, busy, error, load_done;

  int checks = 0;
  int errors = 0;
  logic [ADDR_W-1:0] wa_q[$];
  logic [DATA_W-1:0] wd_q[$];
  int done_cnt = 0;

  program_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5),
                   .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_data_ready(rx_data_ready),
    .write_addr(write_addr), .write_data(write_data), .write_req(write_req),
    .write_ready(write_ready), .system_soft_reset(system_soft_reset), .busy(busy),
    .error(error), .load_done(load_done));

  always #5 clk = ~clk;

  // Record accepted writes and done pulses between edges.
  always @(negedge clk) begin
    #1;
    if (write_req && write_ready) begin
      wa_q.push_back(write_addr);
      wd_q.push_back(write_data);
    end
    if (load_done) done_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task send_byte(input logic [7:0] b);
    rx_data = b;
    rx_data_ready = 1'b1;
    @(negedge clk);
    rx_data_ready = 1'b0;
    @(negedge clk);
  endtask

  task send_hdr(input logic [31:0] cnt, input logic [31:0] base);
    send_byte(8'hA5);
    for (int i = 0; i < 4; i++) send_byte(cnt[8*i +: 8]);
    for (int i = 0; i < 4; i++) send_byte(base[8*i +: 8]);
  endtask

  task send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task test_reset;
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({write_req, system_soft_reset, busy, error, load_done} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 00000",
               {write_req, system_soft_reset, busy, error, load_done});
    end
    checks++;
    if ({write_addr, write_data} !== '0) begin
      errors++;
      $display("FAIL reset_bus got %h/%h want 0/0", write_addr, write_data);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task test_basic;
    int i0, d0;
    i0 = wa_q.size();
    d0 = done_cnt;
    send_byte(8'hA5);
    checks++;
    if ({system_soft_reset, busy, error} !== 3'b110) begin
      errors++;
      $display("FAIL basic_start got %b want 110", {system_soft_reset, busy, error});
    end
    for (int i = 0; i < 4; i++) send_byte(i == 0 ? 8'h02 : 8'h00);
    for (int i = 0; i < 4; i++) send_byte(i == 0 ? 8'h10 : 8'h00);
    send_word(32'h11223344);
    checks++;
    if (system_soft_reset !== 1'b1) begin
      errors++;
      $display("FAIL basic_srst_mid got %b want 1", system_soft_reset);
    end
    send_word(32'hAABBCCDD);
    checks++;
    if ({system_soft_reset, busy, load_done, error} !== 4'b0010) begin
      errors++;
      $display("FAIL basic_finish got %b want 0010",
               {system_soft_reset, busy, load_done, error});
    end
    @(negedge clk);
    checks++;
    if (load_done !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_pulse got %b want 0", load_done);
    end
    @(negedge clk);
    checks++;
    if (wa_q.size() - i0 != 2 || done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL basic_counts got %0d writes %0d dones want 2 1",
               wa_q.size() - i0, done_cnt - d0);
    end else begin
      checks++;
      if ({wa_q[i0], wd_q[i0], wa_q[i0+1], wd_q[i0+1]} !==
          {11'h010, 32'h11223344, 11'h011, 32'hAABBCCDD}) begin
        errors++;
        $display("FAIL basic_writes got %h:%h %h:%h want 010:11223344 011:aabbccdd",
                 wa_q[i0], wd_q[i0], wa_q[i0+1], wd_q[i0+1]);
      end
    end
  endtask

  task test_wrap;
    int i0, d0;
    i0 = wa_q.size();
    d0 = done_cnt;
    send_hdr(32'd2, 32'h0000_07FF);
    send_word(32'h11223344);
    send_word(32'hAABBCCDD);
    repeat (2) @(negedge clk);
    checks++;
    if (wa_q.size() - i0 != 2 || done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL wrap_counts got %0d writes %0d dones want 2 1",
               wa_q.size() - i0, done_cnt - d0);
    end else begin
      checks++;
      if ({wa_q[i0], wa_q[i0+1]} !== {11'h7FF, 11'h000}) begin
        errors++;
        $display("FAIL wrap_addr got %h %h want 7ff 000", wa_q[i0], wa_q[i0+1]);
      end
    end
  endtask

  task test_overrun;
    int i0, d0;
    write_ready = 1'b0;
    i0 = wa_q.size();
    d0 = done_cnt;
    send_hdr(32'd2, 32'h0000_0020);
    send_word(32'h01020304);
    checks++;
    if ({write_req, write_addr, write_data} !== {1'b1, 11'h020, 32'h01020304}) begin
      errors++;
      $display("FAIL ovr_pending got %b %h %h want 1 020 01020304",
               write_req, write_addr, write_data);
    end
    send_word(32'h05060708);
    checks++;
    if ({system_soft_reset, busy, error, write_req, load_done} !== 5'b10100) begin
      errors++;
      $display("FAIL ovr_flags got %b want 10100",
               {system_soft_reset, busy, error, write_req, load_done});
    end
    write_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (wa_q.size() - i0 != 0 || done_cnt - d0 != 0 || error !== 1'b1) begin
      errors++;
      $display("FAIL ovr_after got %0d writes %0d dones err %b want 0 0 1",
               wa_q.size() - i0, done_cnt - d0, error);
    end
  endtask

  task test_timeout;
    int i0, d0;
    send_hdr(32'd2, 32'h0000_0040);
    checks++;
    if ({error, busy} !== 2'b01) begin
      errors++;
      $display("FAIL tmo_restart got %b want 01", {error, busy});
    end
    repeat (98) @(negedge clk);
    checks++;
    if (error !== 1'b0) begin
      errors++;
      $display("FAIL tmo_early got %b want 0", error);
    end
    @(negedge clk);
    checks++;
    if ({error, busy, system_soft_reset} !== 3'b101) begin
      errors++;
      $display("FAIL tmo_fire got %b want 101", {error, busy, system_soft_reset});
    end
    i0 = wa_q.size();
    d0 = done_cnt;
    send_hdr(32'd2, 32'h0000_0050);
    send_word(32'hCAFEF00D);
    send_word(32'h0BADBEEF);
    repeat (2) @(negedge clk);
    checks++;
    if (wa_q.size() - i0 != 2 || done_cnt - d0 != 1 ||
        {error, system_soft_reset} !== 2'b00) begin
      errors++;
      $display("FAIL tmo_reload got %0d writes %0d dones err/srst %b want 2 1 00",
               wa_q.size() - i0, done_cnt - d0, {error, system_soft_reset});
    end else begin
      checks++;
      if ({wa_q[i0+1], wd_q[i0+1]} !== {11'h051, 32'h0BADBEEF}) begin
        errors++;
        $display("FAIL tmo_reload_data got %h:%h want 051:0badbeef", wa_q[i0+1], wd_q[i0+1]);
      end
    end
  endtask

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  task test_checksum;
    int d0;
    d0 = done_cnt;
    send_hdr(32'd2, 32'h0000_0010);
    send_word(32'h11223344);
    send_word(32'hAABBCCDD);
    send_byte(8'h36);
    repeat (2) @(negedge clk);
    checks++;
    if (done_cnt - d0 != 1 || {error, system_soft_reset} !== 2'b00) begin
      errors++;
      $display("FAIL chk_good got %0d dones err/srst %b want 1 00",
               done_cnt - d0, {error, system_soft_reset});
    end
    d0 = done_cnt;
    send_hdr(32'd2, 32'h0000_0010);
    send_word(32'h11223344);
    send_word(32'hAABBCCDD);
    send_byte(8'h37);
    repeat (2) @(negedge clk);
    checks++;
    if (done_cnt - d0 != 0 || {error, system_soft_reset} !== 2'b11) begin
      errors++;
      $display("FAIL chk_bad got %0d dones err/srst %b want 0 11",
               done_cnt - d0, {error, system_soft_reset});
    end
  endtask
`endif

  task test_reset_mid;
    int i0, d0;
    send_hdr(32'd2, 32'h0000_0060);
    send_byte(8'h44);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({write_req, system_soft_reset, busy, error, load_done} !== 5'b0 ||
        {write_addr, write_data} !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs got %b %h %h want 00000 0 0",
               {write_req, system_soft_reset, busy, error, load_done},
               write_addr, write_data);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    send_byte(8'h00);
    send_byte(8'hFF);
    checks++;
    if ({busy, system_soft_reset, error} !== 3'b000) begin
      errors++;
      $display("FAIL rstmid_stray got %b want 000", {busy, system_soft_reset, error});
    end
    i0 = wa_q.size();
    d0 = done_cnt;
    send_hdr(32'd2, 32'h0000_0070);
    send_word(32'h76543210);
    send_word(32'hFEDCBA98);
    repeat (2) @(negedge clk);
    checks++;
    if (wa_q.size() - i0 != 2 || done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL rstmid_counts got %0d writes %0d dones want 2 1",
               wa_q.size() - i0, done_cnt - d0);
    end else begin
      checks++;
      if ({wa_q[i0], wd_q[i0], wa_q[i0+1], wd_q[i0+1]} !==
          {11'h070, 32'h76543210, 11'h071, 32'hFEDCBA98}) begin
        errors++;
        $display("FAIL rstmid_writes got %h:%h %h:%h want 070:76543210 071:fedcba98",
                 wa_q[i0], wd_q[i0], wa_q[i0+1], wd_q[i0+1]);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_wrap();
    test_overrun();
    test_timeout();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
